// File: rtl/h264_intra_pkg.sv
// h264_intra_pkg: shared types for the intra 4x4 mode selector.
// Mode enum, FSM state enum and the DC-unavailable default value.
package h264_intra_pkg;

  typedef enum logic [1:0] {
    I4_V  = 2'd0,
    I4_H  = 2'd1,
    I4_DC = 2'd2
  } i4_mode_e;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_DECIDE = 2'd1,
    S_EMIT   = 2'd2
  } i4_state_e;

  function automatic int unsigned dc_default(
    input int unsigned bd
  );
    return 32'd1 << (bd - 1);
  endfunction

endpackage

// File: rtl/h264_intra4x4_sel_sad4.sv
// h264_sad4: combinational sum of four absolute differences.
// Ports: src/pred four packed pixels each, sad result (BITDEPTH+2 bits).
module h264_sad4 #(
  parameter int BITDEPTH = 8
) (
  input  logic [4*BITDEPTH-1:0] src,
  input  logic [4*BITDEPTH-1:0] pred,
  output logic [BITDEPTH+1:0]   sad
);
  localparam int W = BITDEPTH;

  always_comb begin
    sad = '0;
    for (int i = 0; i < 4; i++) begin
      if (src[i*W +: W] >= pred[i*W +: W])
        sad = sad + (W+2)'(src[i*W +: W] - pred[i*W +: W]);
      else
        sad = sad + (W+2)'(pred[i*W +: W] - src[i*W +: W]);
    end
  end

endmodule

// File: rtl/h264_intra4x4_sel.sv
// h264_intra4x4_sel: intra 4x4 V/H/DC mode decision and residual emit.
// In: CLK, RSTN, row handshake + neighbours; out: residual/base rows, mode fields, SAD.
module h264_intra4x4_sel
  import h264_intra_pkg::*;
#(
  parameter int         BITDEPTH  = 8,
  parameter logic [1:0] MODE_MASK = 2'b11
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      STROBEI,
  output logic                      READYI,
  input  logic [4*BITDEPTH-1:0]     DATAI,
  input  logic [4*BITDEPTH-1:0]     TOPI,
  input  logic [4*BITDEPTH-1:0]     LEFTI,
  input  logic                      TVALID,
  input  logic                      LVALID,
  input  logic [3:0]                PREDMODEI,
  output logic                      STROBEO,
  input  logic                      READYO,
  output logic [4*(BITDEPTH+1)-1:0] DATAO,
  output logic [4*BITDEPTH-1:0]     BASEO,
  output logic [1:0]                ROWO,
  output logic [3:0]                MODEO,
  output logic                      PMODEO,
  output logic [2:0]                RMODEO,
  output logic [BITDEPTH+3:0]       SADO
);
  localparam int W  = BITDEPTH;
  localparam int RW = W + 1;
  localparam int SW = W + 2;
  localparam int AW = W + 4;

  i4_state_e      state, state_nx;
  logic [1:0]     cnt;
  logic [4*W-1:0] rowbuf [4];
  logic [4*W-1:0] top_r, left_r;
  logic           tv_r, lv_r;
  logic [3:0]     pm_r;
  logic [W-1:0]   dc_r;
  logic [AW-1:0]  acc_v, acc_h, acc_dc;
  i4_mode_e       mode_r;

  logic           take, row0;
  logic [4*W-1:0] top_m, left_m;
  logic           tv_m, lv_m;
  logic [SW-1:0]  s_t, s_l, r_t, r_l;
  logic [W+2:0]   s_tl;
  logic [W-1:0]   dc_m, left_y;
  logic [SW-1:0]  sad_v, sad_h, sad_dc;

  i4_mode_e       best_m;
  logic [AW-1:0]  best_s;
  logic [3:0]     mode4;
  logic [2:0]     rem;

  logic [1:0]      e_row;
  i4_mode_e        e_mode;
  logic [4*W-1:0]  e_src, e_base;
  logic [W-1:0]    e_left;
  logic [4*RW-1:0] e_res;

  assign take = STROBEI && READYI && (state == S_LOAD);
  assign row0 = (cnt == 2'd0);

  // Row 0 sees live neighbours; later rows use the captured copy.
  assign top_m  = row0 ? TOPI : top_r;
  assign left_m = row0 ? LEFTI : left_r;
  assign tv_m   = row0 ? TVALID : tv_r;
  assign lv_m   = row0 ? LVALID : lv_r;

  always_comb begin
    s_t = '0;
    s_l = '0;
    for (int i = 0; i < 4; i++) begin
      s_t = s_t + SW'(top_m[i*W +: W]);
      s_l = s_l + SW'(left_m[i*W +: W]);
    end
    s_tl = (W+3)'(s_t) + (W+3)'(s_l) + (W+3)'(4);
    r_t  = s_t + SW'(2);
    r_l  = s_l + SW'(2);
    unique case ({tv_m, lv_m})
      2'b11:   dc_m = s_tl[W+2:3];
      2'b10:   dc_m = r_t[SW-1:2];
      2'b01:   dc_m = r_l[SW-1:2];
      default: dc_m = W'(dc_default(W));
    endcase
  end

  always_comb begin
    left_y = left_m[W-1:0];
    for (int i = 1; i < 4; i++)
      if (cnt == 2'(i)) left_y = left_m[i*W +: W];
  end

  h264_sad4 #(.BITDEPTH(W)) u_sad_v (
    .src (DATAI),
    .pred(top_m),
    .sad (sad_v)
  );

  h264_sad4 #(.BITDEPTH(W)) u_sad_h (
    .src (DATAI),
    .pred({4{left_y}}),
    .sad (sad_h)
  );

  h264_sad4 #(.BITDEPTH(W)) u_sad_dc (
    .src (DATAI),
    .pred({4{dc_m}}),
    .sad (sad_dc)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD:   if (take && cnt == 2'd3) state_nx = S_DECIDE;
      S_DECIDE: state_nx = S_EMIT;
      S_EMIT:   if (READYO && ROWO == 2'd3) state_nx = S_LOAD;
      default:  state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt    <= '0;
      top_r  <= '0;
      left_r <= '0;
      tv_r   <= 1'b0;
      lv_r   <= 1'b0;
      pm_r   <= '0;
      dc_r   <= '0;
      acc_v  <= '0;
      acc_h  <= '0;
      acc_dc <= '0;
      for (int i = 0; i < 4; i++) rowbuf[i] <= '0;
    end else if (take) begin
      rowbuf[cnt] <= DATAI;
      cnt         <= cnt + 2'd1;
      if (row0) begin
        top_r  <= TOPI;
        left_r <= LEFTI;
        tv_r   <= TVALID;
        lv_r   <= LVALID;
        pm_r   <= PREDMODEI;
        dc_r   <= dc_m;
        acc_v  <= AW'(sad_v);
        acc_h  <= AW'(sad_h);
        acc_dc <= AW'(sad_dc);
      end else begin
        acc_v  <= acc_v + AW'(sad_v);
        acc_h  <= acc_h + AW'(sad_h);
        acc_dc <= acc_dc + AW'(sad_dc);
      end
    end
  end

  // Checked from highest mode down with <= so ties fall to the lower mode.
  always_comb begin
    best_m = I4_DC;
    best_s = acc_dc;
    if (MODE_MASK[1] && lv_r && acc_h <= best_s) begin
      best_m = I4_H;
      best_s = acc_h;
    end
    if (MODE_MASK[0] && tv_r && acc_v <= best_s) begin
      best_m = I4_V;
      best_s = acc_v;
    end
    mode4 = {2'b00, best_m};
    rem   = (mode4 < pm_r) ? mode4[2:0] : mode4[2:0] - 3'd1;
  end

  always_comb begin
    e_row  = (state == S_DECIDE) ? 2'd0 : ROWO + 2'd1;
    e_mode = (state == S_DECIDE) ? best_m : mode_r;
    e_src  = rowbuf[e_row];
    e_left = left_r[W-1:0];
    for (int i = 1; i < 4; i++)
      if (e_row == 2'(i)) e_left = left_r[i*W +: W];
    unique case (e_mode)
      I4_V:    e_base = top_r;
      I4_H:    e_base = {4{e_left}};
      default: e_base = {4{dc_r}};
    endcase
    e_res = '0;
    for (int i = 0; i < 4; i++)
      e_res[i*RW +: RW] = {1'b0, e_src[i*W +: W]}
                        - {1'b0, e_base[i*W +: W]};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      READYI  <= 1'b0;
      STROBEO <= 1'b0;
      DATAO   <= '0;
      BASEO   <= '0;
      ROWO    <= '0;
      MODEO   <= '0;
      PMODEO  <= 1'b0;
      RMODEO  <= '0;
      SADO    <= '0;
      mode_r  <= I4_V;
    end else begin
      READYI <= (state_nx == S_LOAD);
      unique case (state)
        S_DECIDE: begin
          STROBEO <= 1'b1;
          DATAO   <= e_res;
          BASEO   <= e_base;
          ROWO    <= 2'd0;
          MODEO   <= mode4;
          PMODEO  <= (mode4 == pm_r);
          RMODEO  <= (mode4 == pm_r) ? 3'd0 : rem;
          SADO    <= best_s;
          mode_r  <= best_m;
        end
        S_EMIT: begin
          if (READYO) begin
            if (ROWO == 2'd3) begin
              STROBEO <= 1'b0;
            end else begin
              ROWO  <= e_row;
              DATAO <= e_res;
              BASEO <= e_base;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_h264_intra4x4_sel.sv
// tb_h264_intra4x4_sel: scoreboard bench for the intra 4x4 selector.
// Drives directed blocks into a default build and a MODE_MASK=0 build.
module tb_h264_intra4x4_sel;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        STROBEI0 = 1'b0, STROBEI1 = 1'b0;
  logic [31:0] DATAI = '0, TOPI = '0, LEFTI = '0;
  logic        TVALID = 1'b0, LVALID = 1'b0;
  logic [3:0]  PREDMODEI = '0;
  logic        READYO0 = 1'b1, READYO1 = 1'b1;

  logic        READYI0, READYI1, STROBEO0, STROBEO1;
  logic [35:0] DATAO0, DATAO1;
  logic [31:0] BASEO0, BASEO1;
  logic [1:0]  ROWO0, ROWO1;
  logic [3:0]  MODEO0, MODEO1;
  logic        PMODEO0, PMODEO1;
  logic [2:0]  RMODEO0, RMODEO1;
  logic [11:0] SADO0, SADO1;

  int total = 0;
  int bad = 0;
  int ro_mode = 0;

  typedef struct packed {
    logic [35:0] data;
    logic [31:0] base;
    logic [1:0]  row;
    logic [3:0]  mode;
    logic        p;
    logic [2:0]  r;
    logic [11:0] sad;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t a0, a1;

  always #5 CLK = ~CLK;

  h264_intra4x4_sel u_dut0 (
    .CLK(CLK), .RSTN(RSTN), .STROBEI(STROBEI0), .READYI(READYI0),
    .DATAI(DATAI), .TOPI(TOPI), .LEFTI(LEFTI), .TVALID(TVALID),
    .LVALID(LVALID), .PREDMODEI(PREDMODEI), .STROBEO(STROBEO0),
    .READYO(READYO0), .DATAO(DATAO0), .BASEO(BASEO0), .ROWO(ROWO0),
    .MODEO(MODEO0), .PMODEO(PMODEO0), .RMODEO(RMODEO0), .SADO(SADO0)
  );

  h264_intra4x4_sel #(.BITDEPTH(8), .MODE_MASK(2'b00)) u_dut1 (
    .CLK(CLK), .RSTN(RSTN), .STROBEI(STROBEI1), .READYI(READYI1),
    .DATAI(DATAI), .TOPI(TOPI), .LEFTI(LEFTI), .TVALID(TVALID),
    .LVALID(LVALID), .PREDMODEI(PREDMODEI), .STROBEO(STROBEO1),
    .READYO(READYO1), .DATAO(DATAO1), .BASEO(BASEO1), .ROWO(ROWO1),
    .MODEO(MODEO1), .PMODEO(PMODEO1), .RMODEO(RMODEO1), .SADO(SADO1)
  );

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] rep(input int v);
    return pk(v, v, v, v);
  endfunction

  function automatic logic [35:0] pr(input int a, input int b,
                                     input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  function automatic logic [35:0] rep9(input int v);
    return pr(v, v, v, v);
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] r0,
    input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [143:0] blk9(input logic [35:0] r0,
    input logic [35:0] r1, input logic [35:0] r2, input logic [35:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  // Monitors: compare the presented row every cycle it is valid
  // (so stalls check holding), pop only when it transfers.
  always @(negedge CLK) begin
    if (RSTN && STROBEO0) begin
      a0.data = DATAO0; a0.base = BASEO0; a0.row = ROWO0;
      a0.mode = MODEO0; a0.p = PMODEO0; a0.r = RMODEO0; a0.sad = SADO0;
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 spurious row: got %h want none", a0);
      end else begin
        check("dut0 row", 128'(a0), 128'(q0[0]));
        if (READYO0) void'(q0.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (RSTN && STROBEO1) begin
      a1.data = DATAO1; a1.base = BASEO1; a1.row = ROWO1;
      a1.mode = MODEO1; a1.p = PMODEO1; a1.r = RMODEO1; a1.sad = SADO1;
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 spurious row: got %h want none", a1);
      end else begin
        check("dut1 row", 128'(a1), 128'(q1[0]));
        if (READYO1) void'(q1.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      case (ro_mode)
        0:       READYO0 = 1'b1;
        1:       READYO0 = ~READYO0;
        default: READYO0 = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  task automatic put_row(input int d, input logic [31:0] v);
    int n = 0;
    @(negedge CLK);
    while (((d == 0) ? READYI0 : READYI1) !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL row accept timeout: got READYI=0 want 1");
    end
    DATAI = v;
    if (d == 0) STROBEI0 = 1'b1;
    else        STROBEI1 = 1'b1;
    @(posedge CLK);
    #1;
    STROBEI0 = 1'b0;
    STROBEI1 = 1'b0;
  endtask

  task automatic send_block(
    input int d, input logic [127:0] src,
    input logic [31:0] top, input logic [31:0] left,
    input bit tv, input bit lv, input logic [3:0] pm,
    input logic [3:0] mode, input bit p, input logic [2:0] r,
    input logic [11:0] sad, input logic [127:0] base,
    input logic [143:0] data, input bit gap
  );
    exp_t e;
    int n;
    for (int y = 0; y < 4; y++) begin
      e.data = data[y*36 +: 36];
      e.base = base[y*32 +: 32];
      e.row  = 2'(y);
      e.mode = mode;
      e.p    = p;
      e.r    = r;
      e.sad  = sad;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    TOPI = top; LEFTI = left; TVALID = tv; LVALID = lv; PREDMODEI = pm;
    for (int y = 0; y < 4; y++) begin
      put_row(d, src[y*32 +: 32]);
      if (y == 0) begin
        TOPI = ~top; LEFTI = ~left; TVALID = !tv; LVALID = !lv;
        PREDMODEI = ~pm;
      end
      if (y == 1 && gap) repeat (3) @(posedge CLK);
    end
    // A stray strobe during DECIDE must not be taken as a row.
    if (d == 0) begin
      STROBEI0 = 1'b1;
      DATAI = 32'hdeadbeef;
    end
    @(negedge CLK);
    if (d == 0) check("decide cycle", 128'({STROBEO0, READYI0}), 128'(2'b00));
    else        check("decide cycle", 128'({STROBEO1, READYI1}), 128'(2'b00));
    @(negedge CLK);
    STROBEI0 = 1'b0;
    if (d == 0) check("first row latency", 128'(STROBEO0), 128'(1'b1));
    else        check("first row latency", 128'(STROBEO1), 128'(1'b1));
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL emit drain timeout: got rows pending want none");
    end
    @(negedge CLK);
    if (d == 0) check("back to load", 128'({STROBEO0, READYI0}), 128'(2'b01));
    else        check("back to load", 128'({STROBEO1, READYI1}), 128'(2'b01));
  endtask

  logic [143:0] z;

  initial begin
    z = blk9(rep9(0), rep9(0), rep9(0), rep9(0));
    #12;
    check("reset outputs dut0", 128'({READYI0, STROBEO0, DATAO0, BASEO0,
          ROWO0, MODEO0, PMODEO0, RMODEO0, SADO0}), 128'(0));
    check("reset outputs dut1", 128'({READYI1, STROBEO1, DATAO1, BASEO1,
          ROWO1, MODEO1, PMODEO1, RMODEO1, SADO1}), 128'(0));
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    check("readyi after reset", 128'(READYI0), 128'(1'b1));

    ro_mode = 0;
    send_block(0, blk(rep(100), rep(100), rep(100), rep(100)),
      rep(100), rep(50), 1, 1, 4'd0, 4'd0, 1, 3'd0, 12'd0,
      blk(rep(100), rep(100), rep(100), rep(100)), z, 0);

    ro_mode = 1;
    send_block(0, blk(rep(10), rep(20), rep(30), rep(40)),
      rep(0), pk(10, 20, 30, 40), 1, 1, 4'd0, 4'd1, 0, 3'd0, 12'd0,
      blk(rep(10), rep(20), rep(30), rep(40)), z, 1);

    ro_mode = 2;
    send_block(0, blk(rep(130), rep(130), rep(130), rep(130)),
      rep(200), rep(10), 0, 0, 4'd0, 4'd2, 0, 3'd1, 12'd32,
      blk(rep(128), rep(128), rep(128), rep(128)),
      blk9(rep9(2), rep9(2), rep9(2), rep9(2)), 0);

    ro_mode = 1;
    send_block(0, blk(rep(77), rep(77), rep(77), rep(77)),
      rep(77), rep(77), 1, 1, 4'd1, 4'd0, 0, 3'd0, 12'd0,
      blk(rep(77), rep(77), rep(77), rep(77)), z, 0);

    ro_mode = 0;
    send_block(0, blk(pk(4, 8, 12, 16), pk(4, 8, 12, 16), rep(0),
      pk(4, 8, 12, 16)), pk(4, 8, 12, 16), pk(4, 8, 12, 16), 1, 0,
      4'd0, 4'd0, 1, 3'd0, 12'd40,
      blk(pk(4, 8, 12, 16), pk(4, 8, 12, 16), pk(4, 8, 12, 16),
      pk(4, 8, 12, 16)),
      blk9(rep9(0), rep9(0), pr(-4, -8, -12, -16), rep9(0)), 0);

    send_block(0, blk(rep(11), rep(11), rep(11), rep(11)),
      pk(0, 0, 0, 42), rep(11), 1, 0, 4'd2, 4'd2, 1, 3'd0, 12'd0,
      blk(rep(11), rep(11), rep(11), rep(11)), z, 0);

    ro_mode = 2;
    send_block(0, blk(rep(1), rep(1), rep(1), rep(1)),
      rep(1), pk(1, 1, 1, 0), 0, 1, 4'd3, 4'd2, 0, 3'd2, 12'd0,
      blk(rep(1), rep(1), rep(1), rep(1)), z, 0);

    ro_mode = 0;
    send_block(0, blk(rep(255), rep(255), rep(255), rep(255)),
      rep(0), rep(0), 1, 1, 4'd0, 4'd0, 1, 3'd0, 12'd4080,
      blk(rep(0), rep(0), rep(0), rep(0)),
      blk9(rep9(255), rep9(255), rep9(255), rep9(255)), 0);

    send_block(0, blk(rep(0), rep(0), rep(0), rep(0)),
      rep(255), rep(255), 1, 1, 4'd8, 4'd0, 0, 3'd0, 12'd4080,
      blk(rep(255), rep(255), rep(255), rep(255)),
      blk9(rep9(-255), rep9(-255), rep9(-255), rep9(-255)), 0);

    // Abort a half-loaded block with reset, then run a fresh one.
    ro_mode = 1;
    TOPI = rep(100); LEFTI = rep(50); TVALID = 1; LVALID = 1;
    PREDMODEI = 4'd0;
    put_row(0, rep(100));
    put_row(0, rep(100));
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("mid reset outputs", 128'({READYI0, STROBEO0, ROWO0, MODEO0,
          SADO0, DATAO0}), 128'(0));
    @(negedge CLK);
    RSTN = 1'b1;
    check("readyi low at release", 128'(READYI0), 128'(1'b0));
    @(negedge CLK);
    check("readyi up after release", 128'(READYI0), 128'(1'b1));
    send_block(0, blk(rep(10), rep(20), rep(30), rep(40)),
      rep(0), pk(10, 20, 30, 40), 1, 1, 4'd0, 4'd1, 0, 3'd0, 12'd0,
      blk(rep(10), rep(20), rep(30), rep(40)), z, 0);

    send_block(1, blk(rep(100), rep(100), rep(100), rep(100)),
      rep(100), rep(50), 1, 1, 4'd5, 4'd2, 0, 3'd2, 12'd400,
      blk(rep(75), rep(75), rep(75), rep(75)),
      blk9(rep9(25), rep9(25), rep9(25), rep9(25)), 0);

    repeat (5) @(negedge CLK);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover rows: got %0d/%0d want 0/0",
               q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
